writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 125 ++++++++++++
 tb/tb_writeback_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: selects link/load/ALU result, extracts big-endian loads, and registers
// the result for the register-file write port and forwarding, counting retired instructions.
module writeback_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_memtoreg,
    input  logic              in_link,
    input  logic              in_regwrite,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [DATA_W-1:0] in_aluout,
    input  logic [DATA_W-1:0] in_readdata,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [1:0]        in_ldsize,
    input  logic              in_ldunsigned,
    input  logic              stall,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_result,
    output logic              misalign,
    output logic [31:0]       retire_cnt
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(NBYTES);
    localparam int unsigned SH_W   = $clog2(DATA_W);

    logic [OFF_W-1:0]         w_off;
    logic [1:0]               w_size;
    logic [SH_W-1:0]          w_sh;
    logic [OFF_W-1:0]         w_align_mask;
    logic [DATA_W-1:0]        w_shift;
    logic signed [DATA_W-1:0] w_sra;
    logic [DATA_W-1:0]        w_srl;
    logic [DATA_W-1:0]        w_load;
    logic [DATA_W-1:0]        w_result;
    logic                     w_misal;
    logic                     w_accept;
    logic                     w_retire;

    logic                     r_valid;
    logic                     r_regwrite;
    logic [REG_AW-1:0]        r_dest;
    logic [DATA_W-1:0]        r_result;
    logic                     r_misalign;
    logic [31:0]              r_retire_cnt;

    assign w_off = in_aluout[OFF_W-1:0];

    always_comb begin
        w_size = in_ldsize;
        if (DATA_W == 32 && in_ldsize == 2'd3) begin
            w_size = 2'd2;
        end
    end

    // Shift the addressed lane to the top, then shift it back down with sign or zero fill.
    assign w_shift      = in_readdata << {w_off, 3'b000};
    assign w_sh         = SH_W'(DATA_W - (8 << w_size));
    assign w_sra        = $signed(w_shift) >>> w_sh;
    assign w_srl        = w_shift >> w_sh;
    assign w_load       = in_ldunsigned ? w_srl : w_sra;
    assign w_align_mask = OFF_W'((1 << w_size) - 1);

    always_comb begin
        w_result = in_aluout;
        w_misal  = 1'b0;
        if (in_link) begin
            w_result = in_pc + DATA_W'(8);
        end else if (in_memtoreg) begin
            w_result = w_load;
            w_misal  = |(w_off & w_align_mask);
        end
    end

    assign in_ready = !stall;
    assign w_accept = in_valid && !stall && !flush;
    assign w_retire = r_valid && (!stall || flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_dest     <= '0;
            r_result   <= '0;
            r_misalign <= 1'b0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (!stall) begin
                r_valid <= in_valid;
            end
            if (w_accept) begin
                r_regwrite <= in_regwrite;
                r_dest     <= in_dest;
                r_result   <= w_result;
                r_misalign <= w_misal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign wb_valid   = r_valid;
    assign misalign   = r_valid && r_misalign;
    assign rf_we      = r_valid && r_regwrite && (r_dest != '0) && !r_misalign;
    assign rf_waddr   = r_dest;
    assign rf_wdata   = r_result;
    assign wb_result  = r_result;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized plus directed bench for writeback_stage at DATA_W=32 and DATA_W=64, checked
// against a byte-level behavioural model of result selection, load extraction and retirement.
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        t_valid;
    logic        t_memtoreg;
    logic        t_link;
    logic        t_regwrite;
    logic [4:0]  t_dest;
    logic [63:0] t_aluout;
    logic [63:0] t_readdata;
    logic [63:0] t_pc;
    logic [1:0]  t_ldsize;
    logic        t_ldunsigned;
    logic        t_stall;
    logic        t_flush;

    logic        d32_ready, d32_we, d32_wbv, d32_mis;
    logic [4:0]  d32_waddr;
    logic [31:0] d32_wdata, d32_wbres, d32_cnt;
    logic        d64_ready, d64_we, d64_wbv, d64_mis;
    logic [4:0]  d64_waddr;
    logic [63:0] d64_wdata, d64_wbres;
    logic [31:0] d64_cnt;

    int checks;
    int failures;

    // Model state per instance: index 0 is DATA_W=32, index 1 is DATA_W=64.
    logic        e_valid [2];
    logic        e_rw    [2];
    logic [4:0]  e_dest  [2];
    logic [63:0] e_res   [2];
    logic        e_mis   [2];
    logic [31:0] e_cnt   [2];

    logic [31:0] saved_cnt;

    writeback_stage #(.DATA_W(32), .REG_AW(5)) dut32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (t_valid),
        .in_ready     (d32_ready),
        .in_memtoreg  (t_memtoreg),
        .in_link      (t_link),
        .in_regwrite  (t_regwrite),
        .in_dest      (t_dest),
        .in_aluout    (t_aluout[31:0]),
        .in_readdata  (t_readdata[31:0]),
        .in_pc        (t_pc[31:0]),
        .in_ldsize    (t_ldsize),
        .in_ldunsigned(t_ldunsigned),
        .stall        (t_stall),
        .flush        (t_flush),
        .rf_we        (d32_we),
        .rf_waddr     (d32_waddr),
        .rf_wdata     (d32_wdata),
        .wb_valid     (d32_wbv),
        .wb_result    (d32_wbres),
        .misalign     (d32_mis),
        .retire_cnt   (d32_cnt)
    );

    writeback_stage #(.DATA_W(64), .REG_AW(5)) dut64 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (t_valid),
        .in_ready     (d64_ready),
        .in_memtoreg  (t_memtoreg),
        .in_link      (t_link),
        .in_regwrite  (t_regwrite),
        .in_dest      (t_dest),
        .in_aluout    (t_aluout),
        .in_readdata  (t_readdata),
        .in_pc        (t_pc),
        .in_ldsize    (t_ldsize),
        .in_ldunsigned(t_ldunsigned),
        .stall        (t_stall),
        .flush        (t_flush),
        .rf_we        (d64_we),
        .rf_waddr     (d64_waddr),
        .rf_wdata     (d64_wdata),
        .wb_valid     (d64_wbv),
        .wb_result    (d64_wbres),
        .misalign     (d64_mis),
        .retire_cnt   (d64_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {misaligned, result}; assembles the load byte by byte, byte 0 being the MSB lane.
    function automatic logic [64:0] model_res(input int w, input logic lnk, input logic m2r,
                                              input logic [63:0] alu, input logic [63:0] rd,
                                              input logic [63:0] pc, input logic [1:0] ls,
                                              input logic uns);
        int          nb;
        int          off;
        int          size;
        int          idx;
        logic [63:0] v;
        logic [7:0]  b;
        logic        mis;
        nb   = w / 8;
        off  = int'(alu[2:0]) % nb;
        size = (ls == 2'd3 && w == 32) ? 4 : (1 << ls);
        mis  = 1'b0;
        if (lnk) begin
            v = pc + 64'd8;
        end else if (m2r) begin
            mis = (off % size) != 0;
            v   = '0;
            for (int i = 0; i < size; i++) begin
                idx = off + i;
                b   = (idx < nb) ? rd[8*(nb-1-idx) +: 8] : 8'h00;
                v   = (v << 8) | {56'b0, b};
            end
            if (!uns && v[8*size-1]) begin
                v = v | ~((64'd1 << (8 * size)) - 64'd1);
            end
        end else begin
            v = alu;
        end
        if (w == 32) begin
            v = v & 64'h0000_0000_FFFF_FFFF;
        end
        return {mis, v};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = 1'b0;
            e_rw[k]    = 1'b0;
            e_dest[k]  = '0;
            e_res[k]   = '0;
            e_mis[k]   = 1'b0;
            e_cnt[k]   = '0;
        end
    endtask

    task automatic check_model();
        logic       we;
        logic [4:0] wa;
        logic [63:0] wd, wr;
        logic [31:0] cn;
        logic       wv, ms;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                we = d32_we; wa = d32_waddr; wd = {32'b0, d32_wdata}; wr = {32'b0, d32_wbres};
                cn = d32_cnt; wv = d32_wbv; ms = d32_mis;
            end else begin
                we = d64_we; wa = d64_waddr; wd = d64_wdata; wr = d64_wbres;
                cn = d64_cnt; wv = d64_wbv; ms = d64_mis;
            end
            chk(k == 0 ? "m32_wb_valid" : "m64_wb_valid", {63'b0, wv}, {63'b0, e_valid[k]});
            chk(k == 0 ? "m32_rf_we" : "m64_rf_we", {63'b0, we},
                {63'b0, e_valid[k] && e_rw[k] && e_dest[k] != 0 && !e_mis[k]});
            chk(k == 0 ? "m32_misalign" : "m64_misalign", {63'b0, ms},
                {63'b0, e_valid[k] && e_mis[k]});
            chk(k == 0 ? "m32_retire_cnt" : "m64_retire_cnt", {32'b0, cn}, {32'b0, e_cnt[k]});
            if (e_valid[k]) begin
                chk(k == 0 ? "m32_rf_waddr" : "m64_rf_waddr", {59'b0, wa}, {59'b0, e_dest[k]});
                if (!e_mis[k]) begin
                    chk(k == 0 ? "m32_rf_wdata" : "m64_rf_wdata", wd, e_res[k]);
                    chk(k == 0 ? "m32_wb_result" : "m64_wb_result", wr, e_res[k]);
                end
            end
        end
        chk("in_ready", {62'b0, d32_ready, d64_ready}, {62'b0, !t_stall, !t_stall});
    endtask

    // Advance the model across the coming rising edge, then compare on the falling edge.
    task automatic tick();
        logic [64:0] r;
        for (int k = 0; k < 2; k++) begin
            if (e_valid[k] && (!t_stall || t_flush)) begin
                e_cnt[k] = e_cnt[k] + 32'd1;
            end
            if (t_valid && !t_stall && !t_flush) begin
                r = model_res(k == 0 ? 32 : 64, t_link, t_memtoreg, t_aluout, t_readdata, t_pc,
                              t_ldsize, t_ldunsigned);
                e_rw[k]   = t_regwrite;
                e_dest[k] = t_dest;
                e_res[k]  = r[63:0];
                e_mis[k]  = r[64];
            end
            if (t_flush) begin
                e_valid[k] = 1'b0;
            end else if (!t_stall) begin
                e_valid[k] = t_valid;
            end
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input logic v, input logic m2r, input logic lnk, input logic rw,
                         input logic [4:0] dst, input logic [63:0] alu, input logic [63:0] rd,
                         input logic [63:0] pc, input logic [1:0] ls, input logic uns);
        t_valid = v; t_memtoreg = m2r; t_link = lnk; t_regwrite = rw; t_dest = dst;
        t_aluout = alu; t_readdata = rd; t_pc = pc; t_ldsize = ls; t_ldunsigned = uns;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, {62'b0, d32_we, d64_we}, 64'd0);
        chk({tag, "_wbv"}, {62'b0, d32_wbv, d64_wbv}, 64'd0);
        chk({tag, "_mis"}, {62'b0, d32_mis, d64_mis}, 64'd0);
        chk({tag, "_waddr"}, {54'b0, d32_waddr, d64_waddr}, 64'd0);
        chk({tag, "_wdata64"}, d64_wdata | {32'b0, d32_wdata}, 64'd0);
        chk({tag, "_wbres64"}, d64_wbres | {32'b0, d32_wbres}, 64'd0);
        chk({tag, "_cnt"}, {d32_cnt, d64_cnt}, 64'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        t_stall  = 1'b0;
        t_flush  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 64'd0, 2'd0, 1'b0);
        model_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Signed byte load at lane 1.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 64'h1001, 64'h11F2_3344, 64'h0, 2'd0, 1'b0);
        tick();
        chk("byte_ld_wdata", {32'b0, d32_wdata}, 64'h0000_0000_FFFF_FFF2);
        chk("byte_ld_we", {63'b0, d32_we}, 64'd1);

        // Link result.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 64'h55, 64'h0, 64'h0040_0010, 2'd0, 1'b0);
        tick();
        chk("link_wdata", {32'b0, d32_wdata}, 64'h0040_0018);
        chk("link_waddr", {59'b0, d32_waddr}, 64'd31);

        // Misaligned half load still retires.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 64'h1003, 64'hCAFE_BABE, 64'h0, 2'd1, 1'b0);
        tick();
        chk("mis_flag", {63'b0, d32_mis}, 64'd1);
        chk("mis_we", {63'b0, d32_we}, 64'd0);
        chk("mis_wbv", {63'b0, d32_wbv}, 64'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 64'hDEAD_BEEF, 64'h0, 64'h0, 2'd2, 1'b0);
        tick();
        chk("mis_cnt", {32'b0, d32_cnt}, 64'd3);
        chk("x0_we", {63'b0, d32_we}, 64'd0);
        chk("x0_wbres", {32'b0, d32_wbres}, 64'hDEAD_BEEF);

        // Stall for three cycles with new inputs offered, then stall with flush.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 64'h1234_5678, 64'h0, 64'h0, 2'd2, 1'b0);
        tick();
        saved_cnt = e_cnt[0];
        t_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 5'(i + 9), 64'(i) + 64'h77, 64'h0, 64'h0, 2'd2, 1'b0);
            tick();
            chk("stall_wdata", {32'b0, d32_wdata}, 64'h1234_5678);
            chk("stall_we", {63'b0, d32_we}, 64'd1);
            chk("stall_cnt", {32'b0, d32_cnt}, {32'b0, saved_cnt});
        end
        t_flush = 1'b1;
        tick();
        chk("stflush_wbv", {62'b0, d32_wbv, d64_wbv}, 64'd0);
        chk("stflush_cnt", {32'b0, d32_cnt}, {32'b0, saved_cnt + 32'd1});
        t_flush = 1'b0;
        t_stall = 1'b0;

        // Reset asserted while an instruction is held by stall.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 64'h6666, 64'h0, 64'h0, 2'd2, 1'b0);
        tick();
        t_stall = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n   = 1'b1;
        t_stall = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 64'hA5A5, 64'h0, 64'h0, 2'd2, 1'b0);
        tick();
        chk("postrst_wbv", {63'b0, d32_wbv}, 64'd1);
        chk("postrst_wdata", {32'b0, d32_wdata}, 64'hA5A5);
        chk("postrst_cnt", {32'b0, d32_cnt}, 64'd0);

        // Counter wrap on the 64-bit instance with an unsigned word load at lane 4.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0, 2'd0, 1'b0);
        tick();
        force dut64.r_retire_cnt = 32'hFFFF_FFFF;
        e_cnt[1] = 32'hFFFF_FFFF;
        tick();
        release dut64.r_retire_cnt;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 64'h2004, 64'h0123_4567_89AB_CDEF, 64'h0, 2'd2, 1'b1);
        tick();
        chk("w64_ld_wdata", d64_wdata, 64'h0000_0000_89AB_CDEF);
        chk("w64_cnt_pre", {32'b0, d64_cnt}, 64'hFFFF_FFFF);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 64'h0, 2'd0, 1'b0);
        tick();
        chk("w64_cnt_wrap", {32'b0, d64_cnt}, 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            t_stall = ($urandom_range(0, 3) == 0);
            t_flush = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 31)), {32'($urandom), 32'($urandom)},
                  {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                  2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
